// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 event filter.
// Contents: decode FSM state encoding, default prefix byte values,
// and the bit layout of one queued event entry {ext, brk, code}.
package ps2_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXT  = 2'd1;
  localparam logic [1:0] S_BRK  = 2'd2;

  localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
  localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;

  // Event entry layout: code occupies [data_w-1:0], then brk, then ext.
  localparam int unsigned EV_CODE_LSB = 0;

  function automatic int unsigned ev_brk_bit(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned ev_ext_bit(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/ps2_event_filter_if.sv
// Bus between the PS/2 receiver / control logic and the event filter.
// master: drives received bytes, strobe, pop and overflow clear.
// slave : the filter; returns head event fields, occupancy, overflow.
interface ps2_event_filter_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_W-1:0]             ps2_Rx;
  logic                          rx_done;
  logic                          rd_en;
  logic                          clr_ovf;
  logic [DATA_W-1:0]             Save;
  logic                          ev_ext;
  logic                          ev_break;
  logic                          ev_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;
  logic                          overflow;

  modport master (
    output ps2_Rx, rx_done, rd_en, clr_ovf,
    input  Save, ev_ext, ev_break, ev_valid, fifo_cnt, overflow
  );

  modport slave (
    input  ps2_Rx, rx_done, rd_en, clr_ovf,
    output Save, ev_ext, ev_break, ev_valid, fifo_cnt, overflow
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst_n (sync active-low), push/din, pop, dout (head entry,
// zero when empty), full, empty, count (occupancy).
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_event_filter.sv
// PS/2 scan-code event filter.
// Decodes make / break / E0-extended byte sequences into key events,
// optionally drops typematic repeats of the held key, and queues events
// in a FWFT FIFO.
// Ports: Clk_F, Reset_F (sync active-low), bus (slave side):
//   ps2_Rx/rx_done in, rd_en pop, clr_ovf clears sticky overflow;
//   Save/ev_ext/ev_break head event, ev_valid, fifo_cnt, overflow out.
module ps2_event_filter
  import ps2_pkg::*;
#(
  parameter int                DATA_W          = 8,
  parameter int                FIFO_DEPTH      = 4,
  parameter logic [DATA_W-1:0] BREAK_CODE      = DATA_W'(BREAK_CODE_DEF),
  parameter logic [DATA_W-1:0] EXT_CODE        = DATA_W'(EXT_CODE_DEF),
  parameter int                REPORT_MAKE     = 1,
  parameter int                SUPPRESS_REPEAT = 1
) (
  input logic               Clk_F,
  input logic               Reset_F,
  ps2_event_filter_if.slave bus
);
  localparam int EW = DATA_W + 2;

  logic [1:0]        state;
  logic              ext;
  logic              held_valid;
  logic              held_ext;
  logic [DATA_W-1:0] held_code;
  logic              overflow_q;

  logic              is_brk_byte;
  logic              is_ext_byte;
  logic              ev_fire;
  logic              ev_is_brk;
  logic              held_match;
  logic              push;
  logic              drop;
  logic [EW-1:0]     entry;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;

  assign is_brk_byte = (bus.ps2_Rx == BREAK_CODE);
  assign is_ext_byte = (bus.ps2_Rx == EXT_CODE);

  // A non-prefix byte completes an event; S_BRK makes it a break.
  always_comb begin
    ev_fire   = 1'b0;
    ev_is_brk = 1'b0;
    if (bus.rx_done && !is_brk_byte && !is_ext_byte) begin
      ev_fire   = 1'b1;
      ev_is_brk = (state == S_BRK);
    end
  end

  // The ext register is 0 in S_IDLE and 1 in S_EXT, so it always carries
  // the extended flag of the event being completed.
  assign held_match = held_valid && (held_ext == ext) && (held_code == bus.ps2_Rx);

  always_comb begin
    push = 1'b0;
    if (ev_fire) begin
      if (ev_is_brk)
        push = 1'b1;
      else
        push = (REPORT_MAKE != 0) && !((SUPPRESS_REPEAT != 0) && held_match);
    end
  end

  // When full, the FIFO is non-empty, so rd_en always yields a real pop.
  assign drop = push && fifo_full && !bus.rd_en;

  always_comb begin
    entry = '0;
    entry[EV_CODE_LSB +: DATA_W]   = bus.ps2_Rx;
    entry[ev_brk_bit(DATA_W)]      = ev_is_brk;
    entry[ev_ext_bit(DATA_W)]      = ext;
  end

  always_ff @(posedge Clk_F) begin
    if (!Reset_F) begin
      state <= S_IDLE;
      ext   <= 1'b0;
    end else if (bus.rx_done) begin
      case (state)
        S_IDLE: begin
          if (is_ext_byte) begin
            state <= S_EXT;
            ext   <= 1'b1;
          end else if (is_brk_byte) begin
            state <= S_BRK;
            ext   <= 1'b0;
          end
        end
        S_EXT: begin
          if (is_brk_byte) begin
            state <= S_BRK;
          end else if (!is_ext_byte) begin
            state <= S_IDLE;
            ext   <= 1'b0;
          end
        end
        S_BRK: begin
          if (!is_brk_byte && !is_ext_byte) begin
            state <= S_IDLE;
            ext   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          ext   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_F) begin
    if (!Reset_F) begin
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= '0;
    end else if (ev_fire) begin
      if (!ev_is_brk && !held_match) begin
        held_valid <= 1'b1;
        held_ext   <= ext;
        held_code  <= bus.ps2_Rx;
      end else if (ev_is_brk && held_match) begin
        held_valid <= 1'b0;
      end
    end
  end

  // Set wins over clear.
  always_ff @(posedge Clk_F) begin
    if (!Reset_F)         overflow_q <= 1'b0;
    else if (drop)        overflow_q <= 1'b1;
    else if (bus.clr_ovf) overflow_q <= 1'b0;
  end

  ps2_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk_F),
    .rst_n (Reset_F),
    .push  (push),
    .din   (entry),
    .pop   (bus.rd_en),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.fifo_cnt)
  );

  assign bus.Save     = head[EV_CODE_LSB +: DATA_W];
  assign bus.ev_break = head[ev_brk_bit(DATA_W)];
  assign bus.ev_ext   = head[ev_ext_bit(DATA_W)];
  assign bus.ev_valid = !fifo_empty;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ps2_event_filter.sv
// Bench for ps2_event_filter: two instances (default config, and a
// break-only / no-suppress / depth-2 config) driven by the same byte
// stream and compared every cycle against a queue-based event model.
module tb_ps2_event_filter;
  localparam int DEPTH0 = 4;
  localparam int DEPTH1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ps2_event_filter_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH0)) bus0 ();
  ps2_event_filter_if #(.DATA_W(8), .FIFO_DEPTH(DEPTH1)) bus1 ();

  ps2_event_filter #(
    .DATA_W          (8),
    .FIFO_DEPTH      (DEPTH0),
    .REPORT_MAKE     (1),
    .SUPPRESS_REPEAT (1)
  ) dut0 (
    .Clk_F   (clk),
    .Reset_F (rst_n),
    .bus     (bus0)
  );

  ps2_event_filter #(
    .DATA_W          (8),
    .FIFO_DEPTH      (DEPTH1),
    .REPORT_MAKE     (0),
    .SUPPRESS_REPEAT (0)
  ) dut1 (
    .Clk_F   (clk),
    .Reset_F (rst_n),
    .bus     (bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Event entry {ext, brk, code}; prefixes tracked as two pending flags.
  int        depth_m [2] = '{DEPTH0, DEPTH1};
  bit        rep_m   [2] = '{1'b1, 1'b0};
  bit        sup_m   [2] = '{1'b1, 1'b0};
  bit        pend_ext[2];
  bit        pend_brk[2];
  bit        held_v  [2];
  bit        held_e  [2];
  bit [7:0]  held_c  [2];
  bit        ovf_m   [2];
  bit [9:0]  q0[$];
  bit [9:0]  q1[$];

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic bit [9:0] qhead(input int d);
    if (qsize(d) == 0) return '0;
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      pend_ext[d] = 0; pend_brk[d] = 0;
      held_v[d] = 0; held_e[d] = 0; held_c[d] = '0;
      ovf_m[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_cycle(input int d, input bit [7:0] b, input bit done,
                             input bit rd, input bit clr);
    bit       have_ev = 0;
    bit [9:0] ev = '0;
    bit       match;
    if (done) begin
      if (b == 8'hE0) begin
        if (!pend_brk[d]) pend_ext[d] = 1;
      end else if (b == 8'hF0) begin
        pend_brk[d] = 1;
      end else begin
        ev    = {pend_ext[d], pend_brk[d], b};
        match = held_v[d] && held_e[d] == pend_ext[d] && held_c[d] == b;
        if (pend_brk[d]) begin
          if (match) held_v[d] = 0;
          have_ev = 1;
        end else begin
          if (!match) begin
            held_v[d] = 1; held_e[d] = pend_ext[d]; held_c[d] = b;
          end
          have_ev = rep_m[d] && !(sup_m[d] && match);
        end
        pend_ext[d] = 0;
        pend_brk[d] = 0;
      end
    end
    if (rd && qsize(d) > 0) begin
      if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (clr) ovf_m[d] = 0;
    if (have_ev) begin
      if (qsize(d) < depth_m[d]) begin
        if (d == 0) q0.push_back(ev); else q1.push_back(ev);
      end else begin
        ovf_m[d] = 1;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [7:0] save, input logic ext,
                           input logic brk, input logic valid, input logic [31:0] cnt,
                           input logic ovf);
    bit [9:0] h = qhead(d);
    chk($sformatf("d%0d_save", d),  {24'd0, save}, {24'd0, h[7:0]});
    chk($sformatf("d%0d_ext", d),   {31'd0, ext},  {31'd0, h[9]});
    chk($sformatf("d%0d_brk", d),   {31'd0, brk},  {31'd0, h[8]});
    chk($sformatf("d%0d_valid", d), {31'd0, valid}, (qsize(d) > 0) ? 32'd1 : 32'd0);
    chk($sformatf("d%0d_cnt", d),   cnt, 32'(qsize(d)));
    chk($sformatf("d%0d_ovf", d),   {31'd0, ovf},  {31'd0, ovf_m[d]});
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic step(input bit [7:0] b, input bit done, input bit rd,
                      input bit clr, input bit rst);
    @(negedge clk);
    bus0.ps2_Rx = b; bus0.rx_done = done; bus0.rd_en = rd; bus0.clr_ovf = clr;
    bus1.ps2_Rx = b; bus1.rx_done = done; bus1.rd_en = rd; bus1.clr_ovf = clr;
    rst_n = !rst;
    @(posedge clk);
    if (rst) model_reset();
    else for (int d = 0; d < 2; d++) model_cycle(d, b, done, rd, clr);
    #1;
    check_dut(0, bus0.Save, bus0.ev_ext, bus0.ev_break, bus0.ev_valid,
              32'(bus0.fifo_cnt), bus0.overflow);
    check_dut(1, bus1.Save, bus1.ev_ext, bus1.ev_break, bus1.ev_valid,
              32'(bus1.fifo_cnt), bus1.overflow);
  endtask

  task automatic send(input bit [7:0] b);
    step(b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (5) pop();
  endtask

  task automatic do_reset();
    repeat (2) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit [7:0] pool [4] = '{8'h1C, 8'h75, 8'h2D, 8'h23};
    int       r;
    bit [7:0] b;

    do_reset();
    chk("rst_cnt", 32'(bus0.fifo_cnt), 32'd0);
    chk("rst_valid", {31'd0, bus0.ev_valid}, 32'd0);

    // make / break
    send(8'h1C);
    chk("tp1_valid_n1", {31'd0, bus0.ev_valid}, 32'd1);
    send(8'hF0);
    send(8'h1C);
    chk("tp1_cnt", 32'(bus0.fifo_cnt), 32'd2);
    chk("tp1_head", {24'd0, bus0.Save}, 32'h1C);
    drain();

    // extended make / break
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("tp2_head_ext", {31'd0, bus0.ev_ext}, 32'd1);
    drain();

    // typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    chk("tp3_cnt", 32'(bus0.fifo_cnt), 32'd3);
    drain();

    // overflow, then full push with simultaneous pop
    send(8'h15); send(8'h16); send(8'h17); send(8'h18); send(8'h19);
    chk("tp4_cnt", 32'(bus0.fifo_cnt), 32'd4);
    chk("tp4_ovf", {31'd0, bus0.overflow}, 32'd1);
    chk("tp4_head", {24'd0, bus0.Save}, 32'h15);
    step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    send(8'h15); send(8'h16); send(8'h17); send(8'h18);
    step(8'h1A, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp4b_cnt", 32'(bus0.fifo_cnt), 32'd4);
    chk("tp4b_ovf", {31'd0, bus0.overflow}, 32'd0);
    drain();

    // break-only instance
    send(8'h2D); send(8'hF0); send(8'h2D);
    chk("tp5_save", {24'd0, bus1.Save}, 32'h2D);
    chk("tp5_cnt", 32'(bus1.fifo_cnt), 32'd1);
    pop();
    chk("tp5_valid", {31'd0, bus1.ev_valid}, 32'd0);
    drain();

    // reset between prefix and code
    send(8'hF0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'h2D);
    chk("tp6_brk", {31'd0, bus0.ev_break}, 32'd0);
    chk("tp6_save", {24'd0, bus0.Save}, 32'h2D);
    drain();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else if (r < 8) b = pool[$urandom_range(0, 3)];
      else            b = 8'($urandom);
      step(b, ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_event_filter.md
Name: ps2_event_filter

Overview:
- Parametrised successor to the team's PS/2 break filter: consumes received scan-code bytes and decodes make, break and E0-extended sequences into key events.
- Optionally suppresses typematic repeats.
- Buffers events in a small first-word-fall-through FIFO.
- Sits between the PS/2 receiver (byte + done strobe) and the keyboard/display control logic.

Parameters:
- DATA_W, 8, scan-code width.
- FIFO_DEPTH, 4, event FIFO entries; power of two, minimum 2.
- BREAK_CODE, 8'hF0, break prefix.
- EXT_CODE, 8'hE0, extended prefix.
- REPORT_MAKE, 1, 1 = push make and break events; 0 = break events only (legacy mode).
- SUPPRESS_REPEAT, 1, 1 = drop a make identical to the currently held key.

Ports:
- Clk_F  in  1  system clock.
- Reset_F  in  1  synchronous, active-low reset.
- ps2_Rx  in  DATA_W  received byte; valid only while rx_done = 1.
- rx_done  in  1  one-cycle byte-valid strobe.
- rd_en  in  1  pop head event; ignored when empty.
- clr_ovf  in  1  clears the overflow flag.
- Save  out  DATA_W  head event code; 0 when empty.
- ev_ext  out  1  head event carried the E0 prefix.
- ev_break  out  1  head event is a break (key release).
- ev_valid  out  1  FIFO non-empty.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Clock and reset: one clock, Clk_F. Reset_F is synchronous and active-low; sampled on the rising edge of Clk_F.
- Reset values: FSM = S_IDLE, ext flag = 0, held-key valid = 0, FIFO empty, Save = 0, ev_ext = 0, ev_break = 0, ev_valid = 0, fifo_cnt = 0, overflow = 0.
- Reset mid-sequence discards any partial prefix and all queued events.
- Bytes are processed only in cycles where rx_done = 1. Otherwise the FSM holds.
- FSM states: S_IDLE, S_EXT, S_BRK. The ext register is the extended flag for the event being decoded.
- S_IDLE transitions:
  - EXT_CODE -> S_EXT, ext = 1.
  - BREAK_CODE -> S_BRK, ext = 0.
  - other -> emit make{ext = 0, code}, stay in S_IDLE.
- S_EXT transitions:
  - BREAK_CODE -> S_BRK, ext kept at 1.
  - EXT_CODE -> stay.
  - other -> emit make{ext = 1, code}, go to S_IDLE, ext = 0.
- S_BRK transitions:
  - BREAK_CODE or EXT_CODE -> stay; the byte is ignored.
  - other -> emit break{ext, code}, go to S_IDLE, ext = 0.
- Held-key register {valid, ext, code}, used only when SUPPRESS_REPEAT = 1:
  - A make equal to the held key is suppressed (not pushed).
  - A make different from the held key is emitted and becomes the new held key.
  - A break matching the held key clears valid.
  - A break not matching the held key leaves the register unchanged and is still emitted.
- REPORT_MAKE = 0: make events are decoded and still update the held key, but are never pushed.
- Event FIFO:
  - Entry is {ext, brk, code}, width DATA_W + 2.
  - Write latency: a byte completing an event at cycle N appears at the head (ev_valid = 1) at cycle N+1 if the FIFO was empty.
  - Outputs are read combinationally from the head entry, FWFT. Save, ev_ext and ev_break are 0 when empty.
- Full and empty rules:
  - Push while full with no pop: event dropped, overflow set to 1.
  - Push while full with a simultaneous rd_en: the pop and push both occur, no drop.
  - Push and pop on a non-empty FIFO: fifo_cnt unchanged.
  - rd_en while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow is cleared by clr_ovf. If clr_ovf and a new drop occur in the same cycle, overflow = 1 (set wins).

Decomposition:
- Shared package ps2_pkg:
  - State encoding for S_IDLE, S_EXT, S_BRK.
  - Default BREAK_CODE / EXT_CODE constants.
  - Event-entry field offsets (code, brk, ext).
- Natural sub-module: ps2_event_fifo, a parametrised synchronous FWFT FIFO with width and depth, push, pop, full, empty and count.
- The decode FSM and held-key logic stay in the top module.

Test Plan:
- Reset, then bytes 1C, F0, 1C -> events {make, ext = 0, 1C} then {break, ext = 0, 1C}; fifo_cnt = 2; ev_valid rises one cycle after the 1C strobe.
- Bytes E0, 75, E0, F0, 75 -> {make, ext = 1, 75}, {break, ext = 1, 75}; ext flag = 0 afterwards.
- SUPPRESS_REPEAT = 1, bytes 1C, 1C, 1C, F0, 1C, 1C -> exactly 3 events: make 1C, break 1C, make 1C.
- FIFO_DEPTH = 4, REPORT_MAKE = 1, 5 distinct make codes with no reads -> fifo_cnt = 4, overflow = 1, head = first code. Repeat with rd_en asserted on the 5th push -> no overflow, fifo_cnt stays 4.
- REPORT_MAKE = 0, bytes 2D, F0, 2D -> single event {break, 2D}; Save = 2D; rd_en -> ev_valid = 0, Save = 0.
- Drive Reset_F low for one cycle between F0 and the next byte 2D -> FIFO empty; the 2D that follows is emitted as a make, not a break.
